push_to_axis_multi: RTL
=======================

// Module: push_to_axis_multi
// PURPOSE
//  Merges CHANNELS independent push interfaces (data + clock enable, no backpressure) into one
//  AXI stream with a channel tag. Sits between multi-source acquisition front ends and a single
//  downstream stream consumer. Each channel has its own FIFO, almost-full flag and sticky,
//  clearable overflow flag. The output is arbitrated round-robin.
// PARAMETERS
//  DATA_WIDTH   8                         width of each channel's data word
//  ADDR_WIDTH   4                         per-channel FIFO depth is 2**ADDR_WIDTH words
//  CHANNELS     4                         number of push inputs (>=2)
//  CHAN_WIDTH   2                         width of ochan; 2**CHAN_WIDTH >= CHANNELS
//  AFULL_LIMIT  1<<(ADDR_WIDTH-1)         FIFO occupancy at or above which iafull[i] is set
// PORTS
//  clock     in   1                       single clock, all logic on rising edge
//  reset     in   1                       synchronous, active-high reset
//  idata     in   CHANNELS*DATA_WIDTH     channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//  ienable   in   CHANNELS                push strobe per channel; one word per cycle when high
//  iafull    out  CHANNELS                registered almost-full per channel
//  overflow  out  CHANNELS                sticky per-channel overflow (word dropped)
//  oclear    in   CHANNELS                clears overflow[i]
//  odata     out  DATA_WIDTH              AXI stream data
//  ochan     out  CHAN_WIDTH              source channel of odata
//  ovalid    out  1                       AXI stream valid
//  oready    in   1                       AXI stream ready
// BEHAVIOUR
//  - Reset (clock edge with reset=1): all FIFOs empty, ovalid=0, odata/ochan=0, overflow=0,
//    iafull=all ones, RR pointer=CHANNELS-1 (so channel 0 has first priority).
//    Reset mid-operation discards all stored words, including the one held in the output
//    register, even while ovalid=1 and oready=0.
//  - Per-channel FIFO holds 2**ADDR_WIDTH words; count_i uses ADDR_WIDTH+1 bits.
//    Write on ienable[i] only if count_i < 2**ADDR_WIDTH at the start of the cycle. A pop in
//    the same cycle does not make room for that write.
//  - Full-channel push: word dropped (never overwrites stored data); other channels unaffected.
//  - overflow[i] <= (overflow[i] & ~oclear[i]) | (ienable[i] & full_i). Set wins over clear.
//  - iafull[i] <= (count_i >= AFULL_LIMIT), sampled from the count at the start of the cycle.
//  - Output stage: a single register holding odata/ochan/ovalid.
//    - It loads when (!ovalid || oready) and some FIFO is non-empty. That FIFO pops in the
//      same cycle.
//    - If nothing loads and oready=1, ovalid falls.
//    - While ovalid=1 and oready=0, odata/ochan/ovalid are held stable (AXI rule).
//  - Arbiter: grants the first non-empty channel in order ptr+1, ptr+2, ... (mod CHANNELS),
//    then ptr <= granted channel. Non-empty is judged on count at the start of the cycle.
//  - Latency: a push in cycle n to an idle block gives ovalid=1 in cycle n+2.
//    Sustained throughput is 1 word/cycle with oready=1.
//  - Capacity per channel under stall: 2**ADDR_WIDTH in FIFO plus 1 in the output register,
//    when that channel owns the output register.
//  - Order: words of one channel leave in push order. Inter-channel order is set by the RR
//    arbiter only.
//  - Wrap-around: read/write pointers wrap mod 2**ADDR_WIDTH; count is never corrupted by wrap.
// TESTING
//  1. Reset held 3 cycles with ienable=4'hF
//       -> ovalid=0, overflow=0, iafull=4'hF.
//     First edge after release with no pushes
//       -> iafull=4'h0; FIFOs empty, no output.
//  2. Push 8'hA5 on ch2 in cycle n, oready=1
//       -> cycle n+2: ovalid=1, odata=8'hA5, ochan=2; cycle n+3: ovalid=0.
//  3. All 4 channels push together once (8'h10..8'h13), oready=1
//       -> ochan 0,1,2,3 with data 10,11,12,13 on 4 consecutive cycles.
//  4. oready=0; ch1 pushes 0..16 (17 words)
//       -> overflow[1]=0; iafull[1]=1 once count reaches 8.
//     18th push (value 17)
//       -> overflow[1]=1 next cycle.
//     Raise oready
//       -> 0..16 delivered in order; 17 never appears.
//  5. oclear[1]=1 in the same cycle as another ch1 overflow
//       -> overflow[1] stays 1.
//     oclear[1]=1 with no overflow
//       -> overflow[1]=0 next cycle; other bits untouched.
//  6. ch0 and ch3 push every cycle, oready=1 for 20 cycles
//       -> ochan alternates 0,3,0,3...
//     No overflow; pointer wraps past 2**ADDR_WIDTH without data loss or reordering.

Source files
------------

// File: rtl/push_to_axis_multi.sv
// Merges CHANNELS push-only sources into one tagged AXI stream: a FIFO per channel,
// round-robin arbitration into a single output register.
module push_to_axis_multi #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int CHANNELS    = 4,
    parameter int CHAN_WIDTH  = 2,
    parameter int AFULL_LIMIT = 1 << (ADDR_WIDTH - 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] idata,
    input  logic [CHANNELS-1:0]            ienable,
    output logic [CHANNELS-1:0]            iafull,
    output logic [CHANNELS-1:0]            overflow,
    input  logic [CHANNELS-1:0]            oclear,
    output logic [DATA_WIDTH-1:0]          odata,
    output logic [CHAN_WIDTH-1:0]          ochan,
    output logic                           ovalid,
    input  logic                           oready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(AFULL_LIMIT);
    localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(CHANNELS - 1);

    logic [CHANNELS-1:0]   nonempty;
    logic [CHANNELS-1:0]   full_vec;
    logic [CHANNELS-1:0]   iafull_next;
    logic [CHANNELS-1:0]   overflow_next;
    logic [CHANNELS-1:0]   iafull_reg;
    logic [CHANNELS-1:0]   overflow_reg;
    logic [DATA_WIDTH-1:0] rd_word [CHANNELS];

    logic [CHAN_WIDTH-1:0] rr_ptr_reg;
    logic [CHAN_WIDTH-1:0] grant_idx;
    logic                  any_ready;
    logic                  load;

    logic [DATA_WIDTH-1:0] odata_reg;
    logic [CHAN_WIDTH-1:0] ochan_reg;
    logic                  ovalid_reg;

    // The output register may take a new word when it is empty or being consumed.
    assign load = (!ovalid_reg || oready) && any_ready;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
            logic [ADDR_WIDTH-1:0] wr_ptr_reg;
            logic [ADDR_WIDTH-1:0] rd_ptr_reg;
            logic [ADDR_WIDTH:0]   count_reg;
            logic                  do_write;
            logic                  do_pop;

            // count never exceeds DEPTH, so its MSB alone means full.
            assign full_vec[gi] = count_reg[ADDR_WIDTH];
            assign nonempty[gi] = (count_reg != '0);
            assign do_write     = ienable[gi] && !count_reg[ADDR_WIDTH];
            assign do_pop       = load && (grant_idx == CHAN_WIDTH'(gi));
            assign rd_word[gi]  = mem_reg[rd_ptr_reg];

            assign iafull_next[gi]   = (count_reg >= AFULL_C);
            assign overflow_next[gi] = (overflow_reg[gi] && !oclear[gi])
                                     || (ienable[gi] && full_vec[gi]);

            always_ff @(posedge clock) begin
                if (do_write) begin
                    mem_reg[wr_ptr_reg] <= idata[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (do_write) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (do_pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({do_write, do_pop})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin: scan ptr+1, ptr+2, ... and take the first channel holding data.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any_ready = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(rr_ptr_reg) + k) % CHANNELS;
            if (!any_ready && nonempty[idx]) begin
                any_ready = 1'b1;
                grant_idx = CHAN_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            odata_reg    <= '0;
            ochan_reg    <= '0;
            ovalid_reg   <= 1'b0;
            rr_ptr_reg   <= LAST_CHAN;
            iafull_reg   <= '1;
            overflow_reg <= '0;
        end else begin
            iafull_reg   <= iafull_next;
            overflow_reg <= overflow_next;
            if (load) begin
                odata_reg  <= rd_word[grant_idx];
                ochan_reg  <= grant_idx;
                ovalid_reg <= 1'b1;
                rr_ptr_reg <= grant_idx;
            end else if (oready) begin
                ovalid_reg <= 1'b0;
            end
        end
    end

    assign odata    = odata_reg;
    assign ochan    = ochan_reg;
    assign ovalid   = ovalid_reg;
    assign iafull   = iafull_reg;
    assign overflow = overflow_reg;

endmodule
